// File: rtl/radix4_pkg.sv
// rtl/radix4_pkg.sv - shared types and select-range helpers for the serializer controller
package radix4_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Select value for the first bit of a byte.
  function automatic logic [SEL_W-1:0] sel_first(input bit lsb_first);
    return lsb_first ? 3'd0 : 3'd7;
  endfunction

  // Select value for the final bit of a byte.
  function automatic logic [SEL_W-1:0] sel_last(input bit lsb_first);
    return lsb_first ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/mux8_shift_ctrl_if.sv
// rtl/mux8_shift_ctrl_if.sv - byte input, mux wiring and serial output bundle
interface mux8_shift_ctrl_if;
  import radix4_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       mux_a;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             byte_done;

  // Controller side.
  modport master (
    input  in_data, in_valid, mux_out, ser_ready,
    output in_ready, mux_a, mux_sel, ser_bit, ser_valid, ser_last, byte_done
  );

  // Upstream/downstream/mux side.
  modport slave (
    output in_data, in_valid, mux_out, ser_ready,
    input  in_ready, mux_a, mux_sel, ser_bit, ser_valid, ser_last, byte_done
  );

endinterface

// File: rtl/mux8_1.sv
// rtl/mux8_1.sv - existing 8:1 bit multiplexer driven by the controller
module mux8_1 (
  input  logic [7:0] a,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = a[sel];

endmodule

// File: rtl/mux8_shift_ctrl.sv
// rtl/mux8_shift_ctrl.sv - sequences an external 8:1 mux as a byte-to-serial converter
module mux8_shift_ctrl
  import radix4_pkg::*;
#(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mux8_shift_ctrl_if.master bus
);

  localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(LSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(LSB_FIRST);
  localparam logic [3:0]       GAP_CNT   = 4'(GAP);
  localparam bit               NO_GAP    = (GAP == 0);

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       gap_q, gap_d;
  logic             done_q, done_d;
  logic             rdy_q;

  logic             beat;
  logic             last_beat;
  logic             in_ready;
  logic             accept;

  // Handshake decode; in_ready looks through ser_ready so a new byte can land on the last beat.
  always_comb begin
    beat      = (state_q == ST_SHIFT) && bus.ser_ready;
    last_beat = beat && (sel_q == SEL_LAST);
    in_ready  = rdy_q && ((state_q == ST_IDLE) || (NO_GAP && last_beat));
    accept    = bus.in_valid && in_ready;
  end

  // Next-state, select stepping, byte capture and gap countdown.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.in_data;
          sel_d   = SEL_FIRST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_beat) begin
          done_d = 1'b1;
          if (!NO_GAP) begin
            state_d = ST_GAP;
            gap_d   = GAP_CNT;
          end else if (accept) begin
            a_d   = bus.in_data;
            sel_d = SEL_FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (beat) begin
          sel_d = LSB_FIRST ? sel_q + 1'b1 : sel_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          state_d = ST_IDLE;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= 8'h00;
      sel_q   <= SEL_FIRST;
      gap_q   <= 4'd0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mux_a     = a_q;
  assign bus.mux_sel   = sel_q;
  assign bus.ser_bit   = bus.mux_out;
  assign bus.ser_valid = (state_q == ST_SHIFT);
  assign bus.ser_last  = (state_q == ST_SHIFT) && (sel_q == SEL_LAST);
  assign bus.byte_done = done_q;

endmodule

// File: tb/tb_mux8_shift_ctrl.sv
// tb/tb_mux8_shift_ctrl.sv - directed self-checking bench for mux8_shift_ctrl
module tb_mux8_shift_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux8_shift_ctrl_if if0 ();
  mux8_shift_ctrl_if if1 ();
  mux8_shift_ctrl_if if2 ();

  mux8_shift_ctrl #(.LSB_FIRST(1'b1), .GAP(0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux8_shift_ctrl #(.LSB_FIRST(1'b0), .GAP(0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux8_shift_ctrl #(.LSB_FIRST(1'b1), .GAP(2)) u_gap (.clk(clk), .rst_n(rst_n), .bus(if2));

  mux8_1 m_lsb (.a(if0.mux_a), .sel(if0.mux_sel), .out(if0.mux_out));
  mux8_1 m_msb (.a(if1.mux_a), .sel(if1.mux_sel), .out(if1.mux_out));
  mux8_1 m_gap (.a(if2.mux_a), .sel(if2.mux_sel), .out(if2.mux_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    logic [11:0] got;
    if0.in_valid = 1'b1;
    if0.in_data  = 8'hC3;
    repeat (3) @(negedge clk);
    got = {if0.in_ready, if0.ser_valid, if0.ser_last, if0.byte_done, if0.mux_a};
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", got);
    end
    total++;
    if ({if0.mux_sel, if1.mux_sel} !== {3'd0, 3'd7}) begin
      bad++;
      $display("FAIL reset_sel got=%h/%h exp=0/7", if0.mux_sel, if1.mux_sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (if0.in_ready !== 1'b1 || if0.ser_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b ser_valid=%b exp=1/0", if0.in_ready, if0.ser_valid);
    end
    if0.in_valid = 1'b0;
  endtask

  task automatic test_lsb_first;
    logic [7:0]  seq;
    logic [14:0] got, exp;
    seq = 8'b1010_0101;
    @(negedge clk);
    if0.in_data  = 8'hA5;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {if0.ser_valid, if0.ser_bit, if0.ser_last, if0.mux_sel, if0.mux_a, if0.byte_done};
      exp = {1'b1, seq[7-i], (i == 7), 3'(i), 8'hA5, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL lsb_beat%0d got=%b exp=%b", i, got, exp);
      end
      @(negedge clk);
    end
    total++;
    if ({if0.byte_done, if0.ser_valid} !== 2'b10) begin
      bad++;
      $display("FAIL lsb_done got=%b%b exp=10", if0.byte_done, if0.ser_valid);
    end
    @(negedge clk);
    total++;
    if (if0.byte_done !== 1'b0) begin
      bad++;
      $display("FAIL lsb_done_pulse got=%b exp=0", if0.byte_done);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] seq;
    logic [5:0] got, exp;
    seq = 8'b1010_0101;
    @(negedge clk);
    if1.in_data  = 8'hA5;
    if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {if1.ser_valid, if1.ser_bit, if1.ser_last, if1.mux_sel};
      exp = {1'b1, seq[7-i], (i == 7), 3'(7 - i)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL msb_beat%0d got=%b exp=%b", i, got, exp);
      end
      @(negedge clk);
    end
    total++;
    if ({if1.byte_done, if1.ser_valid} !== 2'b10) begin
      bad++;
      $display("FAIL msb_done got=%b%b exp=10", if1.byte_done, if1.ser_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]  seq;
    logic [13:0] got, exp;
    seq = 8'b0011_1100;
    @(negedge clk);
    if0.in_data  = 8'h3C;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {if0.ser_valid, if0.ser_bit, if0.ser_last, if0.mux_sel, if0.mux_a};
      exp = {1'b1, seq[7-i], (i == 7), 3'(i), 8'h3C};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL bp_beat%0d got=%b exp=%b", i, got, exp);
      end
      if (i == 3) begin
        if0.ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          got = {if0.ser_valid, if0.ser_bit, if0.ser_last, if0.mux_sel, if0.mux_a};
          exp = {1'b1, 1'b1, 1'b0, 3'd3, 8'h3C};
          total++;
          if (got !== exp) begin
            bad++;
            $display("FAIL bp_hold%0d got=%b exp=%b", k, got, exp);
          end
        end
        if0.ser_ready = 1'b1;
      end
      @(negedge clk);
    end
    total++;
    if ({if0.byte_done, if0.ser_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_done got=%b%b exp=10", if0.byte_done, if0.ser_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] seq;
    logic [3:0]  got, exp;
    seq = 16'b1111_0000_0000_1111;
    @(negedge clk);
    if0.in_data  = 8'h0F;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_data  = 8'hF0;
    for (int j = 0; j < 16; j++) begin
      got = {if0.ser_valid, if0.ser_bit, if0.in_ready, if0.byte_done};
      exp = {1'b1, seq[15-j], (j == 7 || j == 15), (j == 8)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%b exp=%b", j, got, exp);
      end
      if (j == 8) if0.in_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if ({if0.byte_done, if0.ser_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_done got=%b%b exp=10", if0.byte_done, if0.ser_valid);
    end
  endtask

  task automatic test_gap;
    logic [7:0] seq;
    logic [2:0] got, exp;
    int         idle;
    bit         seen_ready;
    @(negedge clk);
    if2.in_data  = 8'h0F;
    if2.in_valid = 1'b1;
    @(negedge clk);
    if2.in_data  = 8'h81;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({if2.ser_valid, if2.in_ready} !== 2'b10) begin
        bad++;
        $display("FAIL gap_byte1_beat%0d valid/ready=%b%b exp=10", i, if2.ser_valid, if2.in_ready);
      end
      @(negedge clk);
    end
    idle = 0;
    seen_ready = 1'b0;
    for (int c = 0; c < 10 && !seen_ready; c++) begin
      if (if2.in_ready) seen_ready = 1'b1;
      else begin
        if (!if2.ser_valid) idle++;
        @(negedge clk);
      end
    end
    total++;
    if (!seen_ready || idle != 2) begin
      bad++;
      $display("FAIL gap_idle_cycles got=%0d ready_seen=%0d exp=2/1", idle, seen_ready);
    end
    @(negedge clk);
    if2.in_valid = 1'b0;
    seq = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      got = {if2.ser_valid, if2.ser_bit, if2.ser_last};
      exp = {1'b1, seq[7-i], (i == 7)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL gap_byte2_beat%0d got=%b exp=%b", i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0]  seq;
    logic [15:0] got;
    logic [2:0]  g3, e3;
    @(negedge clk);
    if0.in_data  = 8'hFF;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({if0.ser_valid, if0.ser_bit, if0.mux_sel} !== {2'b11, 3'(i)}) begin
        bad++;
        $display("FAIL rst_mid_beat%0d got=%b%b%h exp=11%h", i, if0.ser_valid, if0.ser_bit, if0.mux_sel, 3'(i));
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {if0.ser_valid, if0.ser_last, if0.byte_done, if0.in_ready, if0.mux_sel, 1'b0, if0.mux_a};
    total++;
    if (got !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_async got=%h exp=0000", got);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({if0.byte_done, if0.ser_last, if0.ser_valid} !== 3'b000) begin
        bad++;
        $display("FAIL rst_mid_hold%0d got=%b exp=000", k, {if0.byte_done, if0.ser_last, if0.ser_valid});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (if0.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_release in_ready=%b exp=1", if0.in_ready);
    end
    if0.in_data  = 8'h01;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    seq = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      g3 = {if0.ser_valid, if0.ser_bit, if0.ser_last};
      e3 = {1'b1, seq[7-i], (i == 7)};
      total++;
      if (g3 !== e3 || if0.mux_sel !== 3'(i)) begin
        bad++;
        $display("FAIL rst_next_beat%0d got=%b sel=%0d exp=%b sel=%0d", i, g3, if0.mux_sel, e3, i);
      end
      @(negedge clk);
    end
    total++;
    if (if0.byte_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_next_done got=%b exp=1", if0.byte_done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if0.in_data = 8'h00; if0.in_valid = 1'b0; if0.ser_ready = 1'b1;
    if1.in_data = 8'h00; if1.in_valid = 1'b0; if1.ser_ready = 1'b1;
    if2.in_data = 8'h00; if2.in_valid = 1'b0; if2.ser_ready = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_gap();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
